sd_grant_skid: RTL and testbench
================================

SD_GRANT_SKID -- requirements
Module: sd_grant_skid

Interface
REQ-001 Parameter: width, default 8, data bits per transfer.
REQ-002 Parameter: inputs, default 2, number of arbiter sources (grant vector width).
REQ-003 Parameter: idw, default 1, source-id bits; integrator sets idw >= ceil(log2(inputs)), min 1.
REQ-004 clk  input  1  sole clock, all state rising-edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-006 c_data  input  width  upstream (round-robin mux) data.
REQ-007 c_grant  input  inputs  one-hot source indication accompanying c_data.
REQ-008 c_srdy  input  1  upstream data valid.
REQ-009 c_drdy  output  1  this block can accept; driven directly from a flop.
REQ-010 p_data  output  width  head-entry data.
REQ-011 p_id  output  idw  binary source index of head entry.
REQ-012 p_srdy  output  1  head entry valid.
REQ-013 p_drdy  input  1  downstream accept.
REQ-014 grant_err  output  1  one-cycle registered pulse: malformed grant accepted.

Function
REQ-015 Two-entry skid buffer; entries hold {id, data}; head = entry0, tail = entry1.
REQ-016 Occupancy state: EMPTY(0), ONE(1), TWO(2); encoded in flops, no other control state.
REQ-017 Push = c_srdy & c_drdy; pop = p_srdy & p_drdy; both evaluated same cycle.
REQ-018 p_srdy = (state != EMPTY); p_data/p_id = entry0 contents; p_data/p_id don't-care while EMPTY.
REQ-019 c_drdy flop = 1 in EMPTY and ONE, 0 in TWO; no combinational path p_drdy -> c_drdy.
REQ-020 Latency: word pushed in cycle N with state EMPTY is presented on p_srdy/p_data in cycle N+1.
REQ-021 EMPTY: push -> ONE, entry0 <= input; no push -> stay.
REQ-022 ONE: push & !pop -> TWO, entry1 <= input; push & pop -> ONE, entry0 <= input; !push & pop -> EMPTY; neither -> stay.
REQ-023 TWO: pop -> ONE, entry0 <= entry1; no pop -> stay; push impossible (c_drdy=0).
REQ-024 Order preserved: words leave in exact push order; no loss or duplication under any p_drdy pattern.
REQ-025 Throughput: with p_drdy held 1 and c_srdy held 1, one transfer per cycle sustained indefinitely.
REQ-026 Id encode: id = index of lowest set bit of c_grant; c_grant == 0 gives id 0.
REQ-027 grant_err asserted in cycle N+1 iff push in cycle N and c_grant not exactly one-hot (zero or >1 bit); the word is still buffered.
REQ-028 grant_err is 0 in every cycle not preceded by a malformed-grant push.
REQ-029 c_grant, c_data ignored when no push.

Reset
REQ-030 During/after reset: state EMPTY, p_srdy 0, c_drdy 1, grant_err 0, entry0/entry1 data and id 0.
REQ-031 Reset mid-operation discards buffered entries; first cycle after deassertion behaves as fresh EMPTY.

Verification
REQ-032 Single word: inputs=4, push c_data=0xA5, c_grant=4'b0100, p_drdy=1 -> next cycle p_srdy=1, p_data=0xA5, p_id=2; following cycle p_srdy=0.
REQ-033 Backpressure fill: p_drdy=0, push 0x11 then 0x22 -> state TWO, c_drdy=0 in cycle after second push; raise p_drdy -> 0x11 then 0x22 out in order, c_drdy=1 after first pop.
REQ-034 Streaming: c_srdy=1, p_drdy=1, data 0..99 incrementing -> 100 words out, one per cycle, in order, c_drdy never 0.
REQ-035 Random p_drdy (50%) and c_srdy (50%), 10000 words -> scoreboard exact order/data/id match, state never exceeds TWO.
REQ-036 Malformed grant: push with c_grant=4'b0110 -> grant_err=1 one cycle, p_id=1; push with c_grant=0 -> grant_err=1, p_id=0.
REQ-037 Reset mid-run: state TWO, assert reset asynchronously between edges -> p_srdy=0, c_drdy=1 immediately; no stale word emitted after release.

Source files
------------

// File: rtl/sd_grant_skid.sv
// Two-entry skid buffer behind a round-robin mux.
// It carries {source id, data} per word, where the source id is encoded from the one-hot grant.
// It also flags any accepted word whose grant was not exactly one-hot.
module sd_grant_skid #(
    parameter int unsigned width  = 8,
    parameter int unsigned inputs = 2,
    parameter int unsigned idw    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [width-1:0]  c_data,
    input  logic [inputs-1:0] c_grant,
    input  logic              c_srdy,
    output logic              c_drdy,
    output logic [width-1:0]  p_data,
    output logic [idw-1:0]    p_id,
    output logic              p_srdy,
    input  logic              p_drdy,
    output logic              grant_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [width-1:0] data1;
    logic [idw-1:0]   id1;

    logic             push_c;
    logic             pop_c;
    logic [idw-1:0]   in_id_c;
    logic             one_hot_c;

    // Handshakes: both directions are evaluated in the same cycle
    assign push_c = c_srdy & c_drdy;
    assign pop_c  = p_srdy & p_drdy;

    // Lowest set grant bit gives the id; a zero grant maps to id 0
    always_comb begin
        in_id_c = '0;
        for (int i = int'(inputs) - 1; i >= 0; i--) begin
            if (c_grant[i]) in_id_c = idw'(i);
        end
    end

    // The grant is well-formed only when exactly one bit is set
    assign one_hot_c = (c_grant != '0) &&
                       ((c_grant & (c_grant - inputs'(1))) == '0);

    // Occupancy FSM.
    // Entry0 drives p_data/p_id directly, and the ready/valid flags are held in flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            p_srdy    <= 1'b0;
            c_drdy    <= 1'b1;
            grant_err <= 1'b0;
            p_data    <= '0;
            p_id      <= '0;
            data1     <= '0;
            id1       <= '0;
        end else begin
            grant_err <= push_c & ~one_hot_c;
            case (state)
                EMPTY: begin
                    if (push_c) begin
                        p_data <= c_data;
                        p_id   <= in_id_c;
                        state  <= ONE;
                        p_srdy <= 1'b1;
                        c_drdy <= 1'b1;
                    end
                end
                ONE: begin
                    if (push_c && !pop_c) begin
                        data1  <= c_data;
                        id1    <= in_id_c;
                        state  <= TWO;
                        c_drdy <= 1'b0;
                    end else if (push_c && pop_c) begin
                        p_data <= c_data;
                        p_id   <= in_id_c;
                    end else if (pop_c) begin
                        state  <= EMPTY;
                        p_srdy <= 1'b0;
                    end
                end
                TWO: begin
                    if (pop_c) begin
                        p_data <= data1;
                        p_id   <= id1;
                        state  <= ONE;
                        c_drdy <= 1'b1;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    p_srdy <= 1'b0;
                    c_drdy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_grant_skid.sv
// Directed and randomized checks for sd_grant_skid (width 8, four sources).
module tb_sd_grant_skid;

    logic       clk;
    logic       reset;
    logic [7:0] c_data;
    logic [3:0] c_grant;
    logic       c_srdy;
    logic       c_drdy;
    logic [7:0] p_data;
    logic [1:0] p_id;
    logic       p_srdy;
    logic       p_drdy;
    logic       grant_err;

    int n_checks = 0;
    int n_fail   = 0;

    sd_grant_skid #(.width(8), .inputs(4), .idw(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .c_data    (c_data),
        .c_grant   (c_grant),
        .c_srdy    (c_srdy),
        .c_drdy    (c_drdy),
        .p_data    (p_data),
        .p_id      (p_id),
        .p_srdy    (p_srdy),
        .p_drdy    (p_drdy),
        .grant_err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       srdy;
        logic [3:0] grant;
        logic [7:0] data;
        logic       drdy;
        logic       e_srdy;
        logic       e_drdy;
        logic [7:0] e_data;
        logic [1:0] e_id;
        logic       e_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] q_data[$];
    logic [1:0] q_id[$];

    initial begin
        logic       err_exp;
        logic       push;
        logic       pop;
        logic [3:0] g;
        logic [1:0] lid;
        int         ones;
        int         pushed;
        int         cyc;

        reset   = 1'b1;
        c_srdy  = 1'b0;
        c_data  = 8'h00;
        c_grant = 4'b0000;
        p_drdy  = 1'b0;

        // Reset state
        cycle();
        check("rst_p_srdy", 32'(p_srdy), 32'd0);
        check("rst_c_drdy", 32'(c_drdy), 32'd1);
        check("rst_err", 32'(grant_err), 32'd0);
        check("rst_p_data", 32'(p_data), 32'd0);
        check("rst_p_id", 32'(p_id), 32'd0);
        reset = 1'b0;
        cycle();
        check("post_rst_p_srdy", 32'(p_srdy), 32'd0);

        // Directed vectors; expectations are the outputs seen after the next edge
        vecs[0]  = '{1'b1, 4'b0100, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 2'd2, 1'b0};
        vecs[1]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0};
        vecs[2]  = '{1'b1, 4'b0001, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 2'd0, 1'b0};
        vecs[3]  = '{1'b1, 4'b1000, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 2'd0, 1'b0};
        vecs[4]  = '{1'b1, 4'b0010, 8'h33, 1'b0, 1'b1, 1'b0, 8'h11, 2'd0, 1'b0};
        vecs[5]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 2'd3, 1'b0};
        vecs[6]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0};
        vecs[7]  = '{1'b1, 4'b0110, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 2'd1, 1'b1};
        vecs[8]  = '{1'b1, 4'b0000, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 2'd0, 1'b1};
        vecs[9]  = '{1'b0, 4'b0000, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h3C, 2'd0, 1'b0};
        vecs[10] = '{1'b0, 4'b0111, 8'hEE, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0};
        vecs[11] = '{1'b0, 4'b0000, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            c_srdy  = vecs[i].srdy;
            c_grant = vecs[i].grant;
            c_data  = vecs[i].data;
            p_drdy  = vecs[i].drdy;
            cycle();
            check($sformatf("vec%0d_p_srdy", i), 32'(p_srdy), 32'(vecs[i].e_srdy));
            check($sformatf("vec%0d_c_drdy", i), 32'(c_drdy), 32'(vecs[i].e_drdy));
            check($sformatf("vec%0d_err", i), 32'(grant_err), 32'(vecs[i].e_err));
            if (vecs[i].e_srdy) begin
                check($sformatf("vec%0d_p_data", i), 32'(p_data), 32'(vecs[i].e_data));
                check($sformatf("vec%0d_p_id", i), 32'(p_id), 32'(vecs[i].e_id));
            end
        end
        c_srdy = 1'b0;

        // Streaming: one word per cycle with no stall
        c_srdy  = 1'b1;
        c_grant = 4'b0001;
        c_data  = 8'd0;
        p_drdy  = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            cycle();
            check("stream_p_srdy", 32'(p_srdy), 32'd1);
            check("stream_p_data", 32'(p_data), 32'(k - 1));
            check("stream_p_id", 32'(p_id), 32'd0);
            check("stream_c_drdy", 32'(c_drdy), 32'd1);
            if (k < 100) c_data = 8'(k);
            else c_srdy = 1'b0;
        end
        cycle();
        check("stream_drained", 32'(p_srdy), 32'd0);

        // Random handshakes against a queue scoreboard
        err_exp = 1'b0;
        pushed  = 0;
        cyc     = 0;
        while ((pushed < 10000 || q_data.size() > 0) && cyc < 60000) begin
            check("rnd_p_srdy", 32'(p_srdy), 32'(q_data.size() > 0));
            check("rnd_c_drdy", 32'(c_drdy), 32'(q_data.size() < 2));
            check("rnd_err", 32'(grant_err), 32'(err_exp));
            if (p_srdy && q_data.size() > 0) begin
                check("rnd_p_data", 32'(p_data), 32'(q_data[0]));
                check("rnd_p_id", 32'(p_id), 32'(q_id[0]));
            end
            c_srdy = (pushed < 10000) ? 1'($urandom_range(1)) : 1'b0;
            p_drdy = 1'($urandom_range(1));
            if ($urandom_range(7) == 0) g = 4'($urandom_range(15));
            else g = 4'b0001 << $urandom_range(3);
            c_grant = g;
            c_data  = 8'($urandom);
            push = c_srdy && c_drdy;
            pop  = p_srdy && p_drdy;
            if (pop && q_data.size() > 0) begin
                void'(q_data.pop_front());
                void'(q_id.pop_front());
            end
            lid  = 2'd0;
            ones = 0;
            for (int b = 3; b >= 0; b--) begin
                if (g[b]) begin
                    lid = 2'(b);
                    ones++;
                end
            end
            if (push) begin
                q_data.push_back(c_data);
                q_id.push_back(lid);
                pushed++;
            end
            err_exp = push && (ones != 1);
            cycle();
            cyc++;
        end
        n_checks++;
        if (cyc >= 60000) begin
            n_fail++;
            $display("FAIL rnd_timeout: pushed %0d words, needed 10000 within 60000 cycles", pushed);
        end
        c_srdy = 1'b0;
        p_drdy = 1'b0;
        cycle();

        // Reset mid-run with both entries occupied
        c_srdy  = 1'b1;
        c_grant = 4'b0001;
        c_data  = 8'h77;
        p_drdy  = 1'b0;
        cycle();
        c_data = 8'h88;
        cycle();
        check("mid_full_c_drdy", 32'(c_drdy), 32'd0);
        c_srdy = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_p_srdy", 32'(p_srdy), 32'd0);
        check("mid_rst_c_drdy", 32'(c_drdy), 32'd1);
        check("mid_rst_err", 32'(grant_err), 32'd0);
        check("mid_rst_p_data", 32'(p_data), 32'd0);
        check("mid_rst_p_id", 32'(p_id), 32'd0);
        cycle();
        reset  = 1'b0;
        p_drdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("mid_no_stale", 32'(p_srdy), 32'd0);
        end
        c_srdy  = 1'b1;
        c_grant = 4'b0010;
        c_data  = 8'h99;
        cycle();
        check("mid_fresh_p_srdy", 32'(p_srdy), 32'd1);
        check("mid_fresh_p_data", 32'(p_data), 32'h99);
        check("mid_fresh_p_id", 32'(p_id), 32'd1);
        c_srdy = 1'b0;
        cycle();
        check("mid_fresh_drain", 32'(p_srdy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
